// File: rtl/bus_decoder_nport.sv
// CPU memory bus decoder: routes each access to one region-selected slave, checks
// permissions, sequences sync-memory or handshake responses and records bus errors.
module bus_decoder_nport #(
    parameter int                               NUM_SLAVES   = 4,
    parameter int                               REGION_LSB   = 16,
    parameter int                               REGION_W     = 4,
    parameter logic [NUM_SLAVES*REGION_W-1:0]   REGION_MAP   = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter logic [NUM_SLAVES-1:0]            SYNC_MASK    = 4'b0011,
    parameter int                               SYNC_LATENCY = 1,
    parameter logic [NUM_SLAVES-1:0]            EXEC_MASK    = 4'b0010,
    parameter logic [NUM_SLAVES-1:0]            DATA_MASK    = 4'b1101,
    parameter logic [NUM_SLAVES-1:0]            WRITE_MASK   = 4'b1101,
    parameter int                               TIMEOUT      = 255,
    parameter logic [31:0]                      ERR_RDATA    = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_valid,
    input  logic                       mem_instr,
    input  logic [31:0]                mem_addr,
    input  logic [3:0]                 mem_wstrb,
    input  logic [31:0]                mem_wdata,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic                       bus_err,
    output logic [NUM_SLAVES-1:0]      s_valid,
    output logic [31:0]                s_addr,
    output logic [3:0]                 s_wstrb,
    output logic [31:0]                s_wdata,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic [31:0]                err_addr,
    output logic [1:0]                 err_cause
);
    localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_MAX = (TIMEOUT > SYNC_LATENCY) ? TIMEOUT : SYNC_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, WAIT_ACK, RESP} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d, dec_sel, rd_sel;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d, addr_q, addr_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic [1:0]         err_cause_q, err_cause_d;
    logic               resp_err_q, resp_err_d;
    logic               dec_hit, dec_ok;
    logic [31:0]        sel_rdata;

    // Downward scan so the lowest matching index is the one left in dec_sel.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (mem_addr[REGION_LSB +: REGION_W] == REGION_MAP[i*REGION_W +: REGION_W]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        if (|mem_wstrb)     dec_ok = !mem_instr && WRITE_MASK[dec_sel];
        else if (mem_instr) dec_ok = EXEC_MASK[dec_sel];
        else                dec_ok = DATA_MASK[dec_sel];
    end

    assign rd_sel    = (state_q == IDLE) ? dec_sel : sel_q;
    assign sel_rdata = s_rdata[32*int'(rd_sel) +: 32];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        resp_err_d  = resp_err_q;
        s_valid     = '0;
        case (state_q)
            IDLE: begin
                // Acceptance is held off while reset is asserted so no strobe escapes.
                if (mem_valid && reset) begin
                    addr_d     = mem_addr;
                    sel_d      = dec_sel;
                    cnt_d      = CNT_W'(1);
                    resp_err_d = 1'b0;
                    if (dec_hit && dec_ok) begin
                        s_valid[dec_sel] = 1'b1;
                        if (SYNC_MASK[dec_sel]) begin
                            state_d = WAIT_SYNC;
                        end else if (s_ready[dec_sel]) begin
                            rdata_d = sel_rdata;
                            state_d = RESP;
                        end else begin
                            state_d = WAIT_ACK;
                        end
                    end else begin
                        state_d     = RESP;
                        resp_err_d  = 1'b1;
                        rdata_d     = ERR_RDATA;
                        err_addr_d  = mem_addr;
                        err_cause_d = dec_hit ? 2'd2 : 2'd1;
                    end
                end
            end
            WAIT_SYNC: begin
                if (cnt_q == CNT_W'(SYNC_LATENCY)) begin
                    rdata_d = sel_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                s_valid[sel_q] = 1'b1;
                if (s_ready[sel_q]) begin
                    rdata_d = sel_rdata;
                    state_d = RESP;
                end else if (TIMEOUT > 0 && cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d     = RESP;
                    resp_err_d  = 1'b1;
                    rdata_d     = ERR_RDATA;
                    err_addr_d  = addr_q;
                    err_cause_d = 2'd3;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_addr_q  <= '0;
            err_cause_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        sel_q  <= sel_d;
        addr_q <= addr_d;
    end

    assign mem_ready = (state_q == RESP);
    assign bus_err   = mem_ready && resp_err_q;
    assign mem_rdata = rdata_q;
    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;
    assign s_addr    = mem_addr;
    assign s_wstrb   = mem_wstrb;
    assign s_wdata   = mem_wdata;
endmodule

// File: tb/tb_bus_decoder_nport.sv
// Randomized bench for bus_decoder_nport: a per-access reference model derives the
// target, permission outcome, response cycle and captured data from the address rules.
module tb_bus_decoder_nport;
    localparam int          NS    = 4;
    localparam int          LAT   = 1;
    localparam int          TMO   = 255;
    localparam logic [15:0] MAP   = 16'h3210;
    localparam logic [3:0]  SMASK = 4'b0011;
    localparam logic [3:0]  EMASK = 4'b0010;
    localparam logic [3:0]  DMASK = 4'b1101;
    localparam logic [3:0]  WMASK = 4'b1101;
    localparam logic [31:0] ERRD  = 32'hDEADBEEF;

    logic           clk = 1'b0;
    logic           reset;
    logic           mem_valid, mem_instr, mem_ready, bus_err;
    logic [31:0]    mem_addr, mem_wdata, mem_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]     mem_wstrb, s_wstrb;
    logic [NS-1:0]  s_valid, s_ready;
    logic [NS*32-1:0] s_rdata;
    logic [1:0]     err_cause;

    bus_decoder_nport #(
        .NUM_SLAVES(NS), .REGION_LSB(16), .REGION_W(4), .REGION_MAP(MAP),
        .SYNC_MASK(SMASK), .SYNC_LATENCY(LAT), .EXEC_MASK(EMASK), .DATA_MASK(DMASK),
        .WRITE_MASK(WMASK), .TIMEOUT(TMO), .ERR_RDATA(ERRD)
    ) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .err_addr(err_addr), .err_cause(err_cause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_rdata, m_err_addr;
    logic [1:0]  m_err_cause;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_slave(input logic [31:0] addr);
        logic [15:0] map;
        map = MAP;
        for (int i = 0; i < NS; i++)
            if (addr[19:16] == map[i*4 +: 4]) return i;
        return -1;
    endfunction

    function automatic bit ref_perm(input int s, input bit instr, input logic [3:0] wstrb);
        if (wstrb != 4'd0) return !instr && WMASK[s];
        if (instr)         return EMASK[s];
        return DMASK[s];
    endfunction

    // One access from its acceptance cycle through its response cycle; returns at the
    // drive point of the cycle right after the response.
    task automatic txn(input bit instr, input logic [31:0] addr, input logic [3:0] wstrb,
                       input int dly, input bit scramble);
        int s, k;
        bit ok, err, sync;
        logic [1:0]  cause;
        logic [3:0]  onehot, exp_v;
        logic [31:0] cap;
        s     = ref_slave(addr);
        ok    = (s >= 0) && ref_perm(s, instr, wstrb);
        sync  = ok && SMASK[s];
        err   = 1'b0;
        cause = 2'd0;
        if (!ok) begin
            k = 1; err = 1'b1; cause = (s < 0) ? 2'd1 : 2'd2;
        end else if (sync) begin
            k = LAT + 1;
        end else if (TMO > 0 && dly > TMO) begin
            k = TMO + 1; err = 1'b1; cause = 2'd3;
        end else begin
            k = dly + 1;
        end
        onehot = ok ? (4'b0001 << s) : 4'b0000;
        cap    = ERRD;
        mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wstrb = wstrb;
        mem_wdata = $urandom;
        for (int c = 0; c <= k; c++) begin
            if (c > 0 && scramble) begin
                mem_addr  = $urandom;
                mem_valid = 1'($urandom_range(0, 1));
            end
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            s_ready = 4'($urandom);
            if (ok && !sync) s_ready[s] = (c == dly);
            @(negedge clk);
            if (c == 0) chk("rdata_hold", mem_rdata, m_rdata);
            if (ok && !err && c == k - 1) cap = s_rdata[32*s +: 32];
            exp_v = (ok && (sync ? (c == 0) : (c < k))) ? onehot : 4'b0000;
            chk("s_valid", 32'(s_valid), 32'(exp_v));
            chk("mem_ready", 32'(mem_ready), 32'(c == k));
            chk("bus_err", 32'(bus_err), 32'((c == k) && err));
            if (c == k) begin
                m_rdata = err ? ERRD : cap;
                if (err) begin
                    m_err_cause = cause;
                    m_err_addr  = addr;
                end
                chk("mem_rdata", mem_rdata, m_rdata);
                chk("err_cause", 32'(err_cause), 32'(m_err_cause));
                chk("err_addr", err_addr, m_err_addr);
            end
            step();
        end
        mem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_ready = 4'($urandom);
            @(negedge clk);
            chk("idle_ready", 32'(mem_ready), 32'd0);
            chk("idle_s_valid", 32'(s_valid), 32'd0);
            step();
        end
    endtask

    task automatic reset_mid_ack();
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0003_0000; mem_wstrb = 4'd0;
        s_ready = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_pre_s_valid", 32'(s_valid), 32'h8);
            step();
        end
        reset = 1'b0;
        mem_valid = 1'b0;
        step();
        @(negedge clk);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_err_cause", 32'(err_cause), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        step();
        reset = 1'b1;
        m_rdata = 32'd0; m_err_addr = 32'd0; m_err_cause = 2'd0;
        s_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abandoned_ready", 32'(mem_ready), 32'd0);
            step();
        end
    endtask

    initial begin
        reset = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
        mem_wstrb = '0; mem_wdata = '0; s_rdata = '0; s_ready = '0;
        m_rdata = '0; m_err_addr = '0; m_err_cause = '0;
        step();
        step();
        @(negedge clk);
        chk("reset_mem_ready", 32'(mem_ready), 32'd0);
        chk("reset_bus_err", 32'(bus_err), 32'd0);
        chk("reset_mem_rdata", mem_rdata, 32'd0);
        chk("reset_err_addr", err_addr, 32'd0);
        chk("reset_err_cause", 32'(err_cause), 32'd0);
        chk("reset_s_valid", 32'(s_valid), 32'd0);
        step();
        reset = 1'b1;

        txn(1'b0, 32'h0000_0010, 4'h0, 0, 1'b0);   // RAM data read
        txn(1'b1, 32'h0001_0004, 4'h0, 0, 1'b0);   // ROM fetch
        txn(1'b0, 32'h0001_0000, 4'h1, 0, 1'b0);   // ROM write denied
        txn(1'b0, 32'h0002_0004, 4'h0, 3, 1'b0);   // MMIO read, late ready
        txn(1'b0, 32'h0005_0000, 4'h0, 0, 1'b0);   // decode miss
        txn(1'b0, 32'h0002_0008, 4'h0, 0, 1'b0);   // MMIO ready in t0
        txn(1'b1, 32'h0002_0000, 4'h0, 0, 1'b0);   // fetch from MMIO denied
        txn(1'b1, 32'h0000_0020, 4'hF, 0, 1'b0);   // write flagged as fetch denied
        txn(1'b0, 32'hFFF0_1234, 4'h0, 0, 1'b0);   // bits outside region ignored
        txn(1'b0, 32'h0002_0010, 4'h0, 300, 1'b0); // handshake timeout
        txn(1'b0, 32'h0000_0040, 4'h0, 0, 1'b0);   // back-to-back RAM reads
        txn(1'b0, 32'h0000_0044, 4'h0, 0, 1'b0);
        txn(1'b0, 32'h0003_0000, 4'h3, 2, 1'b1);   // MMIO write, address scrambled after t0
        txn(1'b0, 32'h0006_0000, 4'h0, 0, 1'b0);
        reset_mid_ack();
        txn(1'b0, 32'h0003_0100, 4'h0, 300, 1'b1); // timeout with scrambled address

        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            logic [3:0]  w;
            a = {12'($urandom), 4'($urandom_range(0, 5)), 16'($urandom)};
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            txn(($urandom_range(0, 3) == 0), a, w, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
